alu_exec_stage: RTL

- Execute-stage ALU: the consumer of the 4-bit ALU operation code produced by the ALU control decoder.
- Takes operand pair plus operation code through a valid/ready handshake and registers a 64-bit result with per-op flags.
- Keeps a persistent NZCV flag register for flag-setting instructions.
- Sits between the register-read stage and the memory/writeback stage of the LEGv8 datapath.

---
 rtl/alu_exec_stage.sv | 137 +++++++++++++
 1 files changed

// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
//
// Execute-stage ALU for the LEGv8 datapath. Takes an operand pair and a 4-bit
// ALU operation code from the register-read stage through a valid/ready
// handshake, and registers the result, a zero flag and an illegal-op flag for
// the memory/writeback stage. A persistent NZCV register is updated by
// accepted, legal, flag-setting operations.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_valid   in   operand/op presented
//   in_ready   out  stage can accept this cycle (combinational)
//   op         in   4-bit ALU operation code
//   a, b       in   WIDTH-bit operands
//   set_flags  in   update NZCV on acceptance
//   out_valid  out  result register holds valid data
//   out_ready  in   downstream accepts result
//   result     out  registered WIDTH-bit result
//   zero       out  registered (result == 0) for legal ops
//   op_err     out  registered: op was not a legal code
//   nzcv       out  persistent flags {N,Z,C,V}
// -----------------------------------------------------------------------------
module alu_exec_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             op_err,
    output logic [3:0]       nzcv
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    localparam int MSB = WIDTH - 1;

    // Registered state: the result stage and the persistent flags.
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_op_err;
    logic [3:0]       r_nzcv;

    // Combinational datapath.
    logic             w_accept;
    logic             w_legal;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // One extra bit on each adder captures carry-out; for subtraction the
    // carry of a + ~b + 1 is the no-borrow (a >= b unsigned) indication.
    assign w_add = {1'b0, a} + {1'b0, b};
    assign w_sub = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);

    // NOTE: every signal driven here gets a default before the case so that
    // no path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_legal = 1'b1;
        w_res   = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        // Plain case matches exactly, so an op carrying X/Z bits hits no
        // item and lands in default as illegal rather than propagating X.
        case (op)
            OP_AND:   w_res = a & b;
            OP_OR:    w_res = a | b;
            OP_ADD: begin
                w_res = w_add[MSB:0];
                w_c   = w_add[WIDTH];
                w_v   = (a[MSB] == b[MSB]) && (w_res[MSB] != a[MSB]);
            end
            OP_SUB: begin
                w_res = w_sub[MSB:0];
                w_c   = w_sub[WIDTH];
                w_v   = (a[MSB] != b[MSB]) && (w_res[MSB] != a[MSB]);
            end
            OP_PASSB: w_res = b;
            OP_NOR:   w_res = ~(a | b);
            default:  w_legal = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_op_err    <= 1'b0;
            r_nzcv      <= 4'b0000;
        end else begin
            if (w_accept) begin
                // Covers simultaneous consume+accept: valid stays high and the
                // register reloads, giving one result per cycle.
                r_out_valid <= 1'b1;
                r_result    <= w_res;
                r_zero      <= w_legal && (w_res == '0);
                r_op_err    <= !w_legal;
                if (w_legal && set_flags) begin
                    r_nzcv <= {w_res[MSB], (w_res == '0), w_c, w_v};
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign op_err    = r_op_err;
    assign nzcv      = r_nzcv;

endmodule
